cmem_seq: RTL and testbench

- Initiator-side sequencer for the 64x16 coefficient memory (active-low CEN/WEN, synchronous read, Q forced to 0 whenever CEN is high).
- Loads a coefficient set from a valid/ready host stream into the memory.
- On each sample trigger, reads the full tap set back in order and presents it to the FIR MAC as a registered coefficient stream.
- Sits between the host/config path and the coefficient memory on one side, and the MAC datapath on the other.

---
 rtl/cmem_seq_if.sv | 36 +++
 rtl/cmem_seq.sv | 126 ++++++++++++
 tb/tb_cmem_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cmem_seq_if.sv
// cmem_seq_if: host load stream, sample trigger, coefficient stream and memory bus of cmem_seq
//   load_start/load_valid/load_data/load_ready/load_done : host coefficient load stream
//   start/busy                                        : read-pass trigger and activity flag
//   coef_valid/coef_data/coef_idx/coef_last           : registered coefficient stream to the MAC
//   mem_CEN/mem_WEN/mem_A/mem_D/mem_Q                 : 64x16 coefficient memory port (active-low CEN/WEN)
//   slave  = the sequencer, master = host/MAC/memory environment
interface cmem_seq_if #(parameter int AW = 6, parameter int DW = 16);
    logic          load_start;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic          load_done;
    logic          start;
    logic          busy;
    logic          coef_valid;
    logic [DW-1:0] coef_data;
    logic [AW-1:0] coef_idx;
    logic          coef_last;
    logic          mem_CEN;
    logic          mem_WEN;
    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_D;
    logic [DW-1:0] mem_Q;

    modport slave (
        input  load_start, load_valid, load_data, start, mem_Q,
        output load_ready, load_done, busy, coef_valid, coef_data, coef_idx, coef_last,
               mem_CEN, mem_WEN, mem_A, mem_D
    );

    modport master (
        output load_start, load_valid, load_data, start, mem_Q,
        input  load_ready, load_done, busy, coef_valid, coef_data, coef_idx, coef_last,
               mem_CEN, mem_WEN, mem_A, mem_D
    );
endinterface

// File: rtl/cmem_seq.sv
// cmem_seq: coefficient memory sequencer, host load stream into memory and per-sample ordered read-out to the MAC
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   bus : cmem_seq_if.slave carrying load stream, start/busy, coefficient stream and memory port
//   Optional macro CMEM_SYM_EN: symmetric coefficients, load NTAPS/2 words and read them forward then mirrored.
module cmem_seq #(
    parameter int NTAPS = 64,
    parameter int AW    = 6,
    parameter int DW    = 16
) (
    input logic       CLK,
    input logic       RST,
    cmem_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
`ifdef CMEM_SYM_EN
    localparam logic [AW-1:0] HALF    = AW'(NTAPS / 2);
    localparam logic [AW-1:0] LD_LAST = AW'(NTAPS / 2 - 1);
    function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] i);
        return (i < HALF) ? i : LAST - i;
    endfunction
`else
    localparam logic [AW-1:0] LD_LAST = LAST;
    function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] i);
        return i;
    endfunction
`endif

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          cen_n, wen_n, done_n;
    logic [AW-1:0] a_n;
    logic [DW-1:0] d_n;
    // read-data pipeline: the tap whose address was on mem_A last cycle now has its data on mem_Q
    logic          p_v;
    logic [AW-1:0] p_idx;

    assign bus.load_ready = state == LOAD;
    assign bus.busy       = state != IDLE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cen_n   = 1'b1;
        wen_n   = 1'b1;
        a_n     = bus.mem_A;
        d_n     = bus.mem_D;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end else if (bus.start) begin
                    state_n = READ;
                    cnt_n   = '0;
                    cen_n   = 1'b0;
                    a_n     = '0;
                end
            end
            LOAD: begin
                if (bus.load_valid) begin
                    cen_n = 1'b0;
                    wen_n = 1'b0;
                    a_n   = cnt;
                    d_n   = bus.load_data;
                    cnt_n = cnt + 1'b1;
                    if (cnt == LD_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            READ: begin
                cen_n = 1'b0;
                if (cnt == LAST) begin
                    // dummy read at A=0 keeps CEN low while the last tap returns on Q
                    state_n = DRAIN;
                    a_n     = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                    a_n   = rd_addr(cnt + 1'b1);
                end
            end
            DRAIN:   state_n = bus.coef_last ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt            <= '0;
            bus.mem_CEN    <= 1'b1;
            bus.mem_WEN    <= 1'b1;
            bus.mem_A      <= '0;
            bus.mem_D      <= '0;
            bus.load_done  <= 1'b0;
            p_v            <= 1'b0;
            p_idx          <= '0;
            bus.coef_valid <= 1'b0;
            bus.coef_data  <= '0;
            bus.coef_idx   <= '0;
            bus.coef_last  <= 1'b0;
        end else begin
            cnt            <= cnt_n;
            bus.mem_CEN    <= cen_n;
            bus.mem_WEN    <= wen_n;
            bus.mem_A      <= a_n;
            bus.mem_D      <= d_n;
            bus.load_done  <= done_n;
            p_v            <= state == READ;
            p_idx          <= cnt;
            bus.coef_valid <= p_v;
            bus.coef_idx   <= p_idx;
            bus.coef_last  <= p_v && p_idx == LAST;
            if (p_v) bus.coef_data <= bus.mem_Q;
        end
    end
endmodule

// File: tb/tb_cmem_seq.sv
// tb_cmem_seq: randomized directed bench for cmem_seq against a tap-list reference model and a behavioural memory
module tb_cmem_seq;
    localparam int NTAPS = 64;
    localparam int AW    = 6;
    localparam int DW    = 16;
`ifdef CMEM_SYM_EN
    localparam int NLD = NTAPS / 2;
`else
    localparam int NLD = NTAPS;
`endif
    localparam logic [63:0] RST_EXP = 64'({1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b1, 1'b1, 6'h0, 16'h0});

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmem_seq_if #(.AW(AW), .DW(DW)) bus();
    cmem_seq #(.NTAPS(NTAPS), .AW(AW), .DW(DW)) dut (.CLK(clk), .RST(rst), .bus(bus));

    // behavioural 64x16 memory: synchronous read, Q forced to 0 whenever CEN is high
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q;
    always @(posedge clk) begin
        if (!bus.mem_CEN) begin
            if (!bus.mem_WEN) mem[bus.mem_A] <= bus.mem_D;
            else              q <= mem[bus.mem_A];
        end
    end
    assign bus.mem_Q = bus.mem_CEN ? '0 : q;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] w [NTAPS];

    // which loaded word supplies tap i
    function automatic int src(input int i);
`ifdef CMEM_SYM_EN
        return (i < NTAPS / 2) ? i : NTAPS - 1 - i;
`else
        return i;
`endif
    endfunction

    function automatic logic [63:0] rvec();
        return 64'({bus.load_ready, bus.load_done, bus.busy, bus.coef_valid, bus.coef_data, bus.coef_idx,
                    bus.coef_last, bus.mem_CEN, bus.mem_WEN, bus.mem_A, bus.mem_D});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input bit rnd, input bit with_start);
        int  k;
        int  cyc;
        bit  v;
        for (int i = 0; i < NLD; i++) begin
`ifdef CMEM_SYM_EN
            w[i] = rnd ? DW'($urandom_range(1, 65535)) : DW'(100 + i);
`else
            w[i] = rnd ? DW'($urandom_range(1, 65535)) : DW'(3 * i + 1);
`endif
        end
        bus.load_start = 1'b1;
        bus.start      = with_start;
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.start      = 1'b0;
        check("load_entry", 64'({bus.load_ready, bus.busy, bus.mem_CEN}), 64'b111);
        k   = 0;
        cyc = 0;
        while (k < NLD && cyc < 4 * NTAPS) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : (cyc % 4 != 3);
            bus.load_valid = v;
            bus.load_data  = v ? w[k] : DW'($urandom);
            @(negedge clk);
            if (v) begin
                check("load_wr", 64'({bus.mem_CEN, bus.mem_WEN, bus.mem_A, bus.mem_D, bus.load_done, bus.load_ready}),
                      64'({1'b0, 1'b0, AW'(k), w[k], k == NLD - 1, k != NLD - 1}));
                k++;
            end else begin
                check("load_gap", 64'({bus.mem_CEN, bus.mem_WEN, bus.load_done, bus.load_ready}), 64'b1101);
            end
            cyc++;
        end
        bus.load_valid = 1'b0;
        check("load_count", 64'(k), 64'(NLD));
        @(negedge clk);
        check("load_done_pulse", 64'({bus.load_done, bus.mem_CEN, bus.busy}), 64'b010);
    endtask

    task automatic do_read(input bit disturb, input int rst_at);
        bit v;
        int idx;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 1; t <= 68; t++) begin
            v   = t >= 3 && t <= 66;
            idx = v ? t - 3 : 0;
            check($sformatf("read_t%0d", t),
                  64'({bus.coef_valid, bus.coef_valid ? bus.coef_idx : AW'(0), bus.coef_valid ? bus.coef_data : DW'(0),
                       bus.coef_last, bus.mem_CEN, bus.mem_WEN, t <= 65 ? bus.mem_A : AW'(0), bus.busy}),
                  64'({v, v ? AW'(idx) : AW'(0), v ? w[src(idx)] : DW'(0),
                       v && idx == NTAPS - 1, t >= 66, 1'b1, t <= 64 ? AW'(src(t - 1)) : AW'(0), t <= 66}));
            if (t == rst_at) begin
                #1 rst = 1'b1;
                #1 check("rst_async", rvec(), RST_EXP);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("rst_quiet", 64'({bus.mem_CEN, bus.busy, bus.coef_valid}), 64'b100);
                end
                return;
            end
            bus.start      = disturb && (t == 10 || t == 66);
            bus.load_start = disturb && (t == 10 || t == 66);
            @(negedge clk);
        end
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        #2 rst = 1'b1;
        #1 check("reset", rvec(), RST_EXP);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle", 64'({bus.mem_CEN, bus.busy, bus.load_ready}), 64'b100);
        do_load(1'b0, 1'b0);
        do_read(1'b0, 0);
        do_read(1'b1, 0);
        do_load(1'b1, 1'b1);
        do_read(1'b0, 23);
        do_read(1'b0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
